// File: rtl/scan_chain_pkg.sv
// Shared types for the scan chain driver.
// State encoding and the fixed select width.
package scan_chain_pkg;
  localparam int SEL_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    LATCH,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_e;
endpackage

// File: rtl/scan_chain_driver_clk_gen.sv
// Scan clock divider: CLK_DIV clk cycles low, CLK_DIV high.
// rise_o/fall_o flag the cycle before the scan_clk edge.
module scan_clk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          ph_q;
  logic          last;

  assign last = (cnt_q == CW'(CLK_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else if (last) begin
      cnt_q <= '0;
      ph_q  <= ~ph_q;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign sclk_o = ph_q;
  assign rise_o = last & ~ph_q;
  assign fall_o = last & ph_q;
endmodule

// File: rtl/scan_chain_driver.sv
// Drives one word into a chain of scan wrappers and reads one back.
// SCAN_FREERUN_EN: refresh continuously, start is ignored.
module scan_chain_driver
  import scan_chain_pkg::*;
#(
  parameter int NUM_DESIGNS = 4,
  parameter int NUM_IOS     = 8,
  parameter int CLK_DIV     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SEL_W-1:0]   active_select,
  input  logic [NUM_IOS-1:0] inputs,
  output logic [NUM_IOS-1:0] outputs,
  output logic               ready,
  output logic               busy,
  output logic               scan_clk,
  output logic               scan_data_out,
  input  logic               scan_data_in,
  output logic               scan_select,
  output logic               scan_latch_enable
);
  localparam int TOTAL = NUM_DESIGNS * NUM_IOS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int BIT_W = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q;
  logic [NUM_IOS-1:0] in_q, cap_q, out_q;
  logic [CNT_W-1:0]   j_q;
  logic [SEL_W-1:0]   dsg_q;
  logic [BIT_W-1:0]   bit_q;
  logic               gclk, rise, fall;
  logic               shifting, last_per, load, hit;

  assign shifting = (state_q == SHIFT_IN) || (state_q == SHIFT_OUT);
  assign last_per = (j_q == CNT_W'(TOTAL - 1));
  assign hit      = (dsg_q == sel_q);
  assign load     = (state_d == SHIFT_IN) &&
                    ((state_q == IDLE) || (state_q == DONE));

  scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_gen (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  ((state_q == IDLE) || (state_q == DONE)),
    .sclk_o (gclk),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef SCAN_FREERUN_EN
      IDLE:      state_d = SHIFT_IN;
      DONE:      state_d = SHIFT_IN;
`else
      IDLE:      if (start) state_d = SHIFT_IN;
      DONE:      state_d = IDLE;
`endif
      SHIFT_IN:  if (fall && last_per) state_d = LATCH;
      LATCH:     if (fall) state_d = CAPTURE;
      CAPTURE:   if (fall) state_d = SHIFT_OUT;
      SHIFT_OUT: if (fall && last_per) state_d = DONE;
      default:   state_d = IDLE;
    endcase
  end

  // Period j targets design dsg_q, bit bit_q (both walk down from the top).
  always_ff @(posedge clk) begin
    if (reset || !shifting) begin
      j_q   <= '0;
      dsg_q <= SEL_W'(NUM_DESIGNS - 1);
      bit_q <= BIT_W'(NUM_IOS - 1);
    end else if (fall) begin
      j_q <= j_q + CNT_W'(1);
      if (bit_q == '0) begin
        bit_q <= BIT_W'(NUM_IOS - 1);
        dsg_q <= dsg_q - SEL_W'(1);
      end else begin
        bit_q <= bit_q - BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
      in_q  <= '0;
      cap_q <= '0;
      out_q <= '0;
    end else begin
      if (load) begin
        sel_q <= active_select;
        in_q  <= inputs;
        cap_q <= '0;
      end
      if ((state_q == SHIFT_OUT) && rise && hit)
        cap_q[bit_q] <= scan_data_in;
      if ((state_q == SHIFT_OUT) && (state_d == DONE))
        out_q <= cap_q;
    end
  end

  always_comb begin
    outputs           = out_q;
    ready             = (state_q == DONE);
    busy              = (state_q != IDLE);
    scan_clk          = gclk && ((state_q == SHIFT_IN) ||
                                 (state_q == CAPTURE) ||
                                 (state_q == SHIFT_OUT));
    scan_data_out     = (state_q == SHIFT_IN) && hit && in_q[bit_q];
    scan_select       = (state_q == CAPTURE);
    scan_latch_enable = (state_q == LATCH);
  end
endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench: two driver instances feeding behavioural wrapper chains.
// Wrapper k returns (latched word + k); expectations come from that rule.
module tb_scan_chain_driver;
  logic       clk = 1'b0;
  logic       rst_a, rst_b, st_a, st_b, sdi_a, sdi_b;
  logic [8:0] sel_a, sel_b;
  logic [7:0] in_a, in_b, out_a, out_b;
  logic       rdy_a, bsy_a, sclk_a, sdo_a, ssel_a, sle_a;
  logic       rdy_b, bsy_b, sclk_b, sdo_b, ssel_b, sle_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_chain_driver u_a (
    .clk(clk), .reset(rst_a), .start(st_a),
    .active_select(sel_a), .inputs(in_a), .outputs(out_a),
    .ready(rdy_a), .busy(bsy_a), .scan_clk(sclk_a),
    .scan_data_out(sdo_a), .scan_data_in(sdi_a),
    .scan_select(ssel_a), .scan_latch_enable(sle_a)
  );

  scan_chain_driver #(.NUM_DESIGNS(2), .CLK_DIV(3)) u_b (
    .clk(clk), .reset(rst_b), .start(st_b),
    .active_select(sel_b), .inputs(in_b), .outputs(out_b),
    .ready(rdy_b), .busy(bsy_b), .scan_clk(sclk_b),
    .scan_data_out(sdo_b), .scan_data_in(sdi_b),
    .scan_select(ssel_b), .scan_latch_enable(sle_b)
  );

  // Wrapper chain models: serial in at bit 0, serial out at the top bit.
  logic [31:0] ch_a = '0;
  logic [15:0] ch_b = '0;
  logic [7:0]  lat_a [4];
  logic [7:0]  lat_b [2];

  initial begin
    for (int k = 0; k < 4; k++) lat_a[k] = '0;
    for (int k = 0; k < 2; k++) lat_b[k] = '0;
  end

  always @(posedge sclk_a)
    if (ssel_a) for (int k = 0; k < 4; k++) ch_a[k*8 +: 8] <= lat_a[k] + 8'(k);
    else        ch_a <= {ch_a[30:0], sdo_a};

  always @(posedge sclk_b)
    if (ssel_b) for (int k = 0; k < 2; k++) ch_b[k*8 +: 8] <= lat_b[k] + 8'(k);
    else        ch_b <= {ch_b[14:0], sdo_b};

  always @(posedge clk) begin
    if (sle_a) for (int k = 0; k < 4; k++) lat_a[k] <= ch_a[k*8 +: 8];
    if (sle_b) for (int k = 0; k < 2; k++) lat_b[k] <= ch_b[k*8 +: 8];
  end

  assign sdi_a = ch_a[31];
  assign sdi_b = ch_b[15];

  // Scan clock shape and data stability monitor on the divided instance.
  int   hi_b = 0, lo_b = 0, bad_clk_b = 0, bad_dat_b = 0;
  logic sclk_bp = 1'b0, sdo_bp = 1'b0, lat_seen_b = 1'b0;

  always @(negedge clk) begin
    if (sclk_b && (sdo_b !== sdo_bp)) bad_dat_b <= bad_dat_b + 1;
    if (sclk_b) begin
      if (!sclk_bp && !lat_seen_b && lo_b != 3) bad_clk_b <= bad_clk_b + 1;
      hi_b       <= hi_b + 1;
      lo_b       <= 0;
      lat_seen_b <= 1'b0;
    end else begin
      if (sclk_bp && hi_b != 3) bad_clk_b <= bad_clk_b + 1;
      hi_b <= 0;
      lo_b <= bsy_b ? lo_b + 1 : 0;
      if (sle_b) lat_seen_b <= 1'b1;
    end
    sclk_bp <= sclk_b;
    sdo_bp  <= sdo_b;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_out(input int n, input logic [8:0] s,
                                         input logic [7:0] d);
    return (int'(s) < n) ? d + 8'(s) : 8'h00;
  endfunction

  task automatic run_a(input logic [8:0] s, input logic [7:0] d,
                       input bit poke, input int exp_len);
    int n;
    @(negedge clk);
    sel_a = s; in_a = d; st_a = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      st_a = poke && (n == 50);
      if (n == 1) begin
        sel_a = 9'($urandom);
        in_a  = 8'($urandom);
      end
    end while (!rdy_a && n < 400);
    chk("a_len", n, exp_len);
    chk("a_out", out_a, ref_out(4, s, d));
    for (int k = 0; k < 4; k++)
      chk("a_latch", lat_a[k], (int'(s) == k) ? d : 8'h00);
    @(negedge clk);
    chk("a_idle", {rdy_a, bsy_a}, 2'b00);
    repeat (4) @(negedge clk);
    chk("a_hold", {bsy_a, out_a}, {1'b0, ref_out(4, s, d)});
  endtask

  task automatic run_b(input logic [8:0] s, input logic [7:0] d,
                       input int exp_len);
    int n;
    @(negedge clk);
    sel_b = s; in_b = d; st_b = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      st_b = 1'b0;
      if (n == 1) in_b = 8'($urandom);
    end while (!rdy_b && n < 1000);
    chk("b_len", n, exp_len);
    chk("b_out", out_b, ref_out(2, s, d));
    for (int k = 0; k < 2; k++)
      chk("b_latch", lat_b[k], (int'(s) == k) ? d : 8'h00);
    @(negedge clk);
    chk("b_idle", bsy_b, 1'b0);
  endtask

  task automatic wait_ra(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_a && n < 1000);
    if (n >= 1000) chk("a_timeout", n, 0);
  endtask

  initial begin
    int n, len_a, len_b, seen;
    logic [8:0] s;
    logic [7:0] d;
    len_a = (2 * 32 + 2) * 2 * 1 + 1;
    len_b = (2 * 16 + 2) * 2 * 3 + 1;
    rst_a = 1'b1; rst_b = 1'b1; st_a = 1'b0; st_b = 1'b0;
    sel_a = '0; sel_b = '0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_a", {out_a, rdy_a, bsy_a, sclk_a, sdo_a, ssel_a, sle_a}, '0);
    chk("rst_b", {out_b, rdy_b, bsy_b, sclk_b, sdo_b, ssel_b, sle_b}, '0);
`ifdef SCAN_FREERUN_EN
    sel_a = 9'd1; in_a = 8'h20;
    rst_a = 1'b0; rst_b = 1'b0;
    wait_ra(n);
    wait_ra(n);
    chk("fr_per", n, len_a);
    chk("fr_out", out_a, 8'h21);
    repeat (20) @(negedge clk);
    in_a = 8'h40;
    wait_ra(n);
    chk("fr_old", out_a, 8'h21);
    wait_ra(n);
    chk("fr_new", out_a, 8'h41);
    chk("fr_per2", n, len_a);
`else
    rst_a = 1'b0; rst_b = 1'b0;
    run_a(9'd2, 8'h11, 1'b0, len_a);
    for (int i = 0; i < 4; i++) run_a(9'(i), 8'hA5, 1'b0, len_a);
    run_a(9'd4, 8'hFF, 1'b0, len_a);
    run_a(9'd300, 8'h5C, 1'b0, len_a);
    run_a(9'd1, 8'h3C, 1'b1, len_a);
    for (int i = 0; i < 6; i++) begin
      s = 9'($urandom_range(0, 5));
      d = 8'($urandom);
      run_a(s, d, 1'b0, len_a);
    end
    // Abort a refresh partway through.
    @(negedge clk);
    sel_a = 9'd3; in_a = 8'h77; st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    repeat (39) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    chk("mid_rst", {out_a, rdy_a, bsy_a, sclk_a, sdo_a, ssel_a, sle_a}, '0);
    rst_a = 1'b0;
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (rdy_a || bsy_a) seen++;
    end
    chk("no_ready", seen, 0);
    run_a(9'd0, 8'hC3, 1'b0, len_a);
    for (int i = 0; i < 3; i++) begin
      s = 9'($urandom_range(0, 2));
      d = 8'($urandom);
      run_b(s, d, len_b);
    end
    chk("b_clk_shape", bad_clk_b, 0);
    chk("b_data_stable", bad_dat_b, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
